// File: rtl/krun_pkg.sv
// krun_pkg: shared widths, dataset count and run-controller state encoding
package krun_pkg;
   localparam int KRUN_CNT_W       = 16;
   localparam int KRUN_DATASET_NUM = 8;
   localparam int KRUN_DS_W        = (KRUN_DATASET_NUM > 1) ? $clog2(KRUN_DATASET_NUM) : 1;
   localparam int KRUN_GAP_W       = 8;
   localparam int KRUN_CYC_W       = 32;
   typedef logic [2:0] krun_state_t;
   localparam krun_state_t IDLE      = 3'd0;
   localparam krun_state_t ARM       = 3'd1;
   localparam krun_state_t START     = 3'd2;
   localparam krun_state_t WAIT_DONE = 3'd3;
   localparam krun_state_t GAP       = 3'd4;
   localparam krun_state_t FINISH    = 3'd5;
endpackage

// File: rtl/sync_edge_det.sv
// sync_edge_det: 2-flop synchronizer plus registered rising-edge pulse
module sync_edge_det (
   input  logic ap_clk,
   input  logic ap_rst_n,
   input  logic d,
   output logic rise
);
   logic [2:0] s;
   always_ff @(posedge ap_clk or negedge ap_rst_n) begin
      if (!ap_rst_n) begin
         s    <= '0;
         rise <= 1'b0;
      end else begin
         s    <= {s[1:0], d};
         rise <= s[1] & ~s[2];
      end
   end
endmodule

// File: rtl/kernel_run_ctrl.sv
// kernel_run_ctrl: batches back-to-back ap_ctrl_hs kernel runs with a gap and dataset stepping
// KRUN_CYCLE_STATS_EN adds last_run_cyc / batch_cyc cycle statistics
module kernel_run_ctrl
   import krun_pkg::*;
#(
   parameter int CNT_W       = KRUN_CNT_W,
   parameter int DATASET_NUM = KRUN_DATASET_NUM,
   parameter int DS_W        = KRUN_DS_W,
   parameter int GAP_W       = KRUN_GAP_W
`ifdef KRUN_CYCLE_STATS_EN
   ,parameter int CYC_W      = KRUN_CYC_W
`endif
) (
   input  logic             ap_clk,
   input  logic             ap_rst_n,
   input  logic             trig_in,
   input  logic             stop_req,
   input  logic [CNT_W-1:0] run_count_cfg,
   input  logic [GAP_W-1:0] gap_cfg,
   output logic             kern_ap_start,
   input  logic             kern_ap_ready,
   input  logic             kern_ap_done,
   input  logic             kern_ap_idle,
   output logic [DS_W-1:0]  dataset_sel,
   output logic             dataset_adv,
   output logic             busy,
   output logic             batch_done,
   output logic [CNT_W-1:0] iter_cnt
`ifdef KRUN_CYCLE_STATS_EN
   ,output logic [CYC_W-1:0] last_run_cyc,
   output logic [CYC_W-1:0]  batch_cyc
`endif
);
   krun_state_t      st, nxt;
   logic             trig_rise, stop_p, stop, done_ev, fin;
   logic [CNT_W-1:0] cnt_l;
   logic [GAP_W-1:0] gap_l, gcnt;

   sync_edge_det u_trig (.ap_clk(ap_clk), .ap_rst_n(ap_rst_n), .d(trig_in), .rise(trig_rise));

   // ready+done together in START counts as a completed run
   always_comb begin
      stop    = stop_p | stop_req;
      done_ev = kern_ap_done && (st == WAIT_DONE || (st == START && kern_ap_ready));
      fin     = stop || (cnt_l != '0 && iter_cnt == cnt_l - CNT_W'(1));
      nxt     = fin ? FINISH : (gap_l == '0 ? ARM : GAP);
   end

   always_ff @(posedge ap_clk or negedge ap_rst_n) begin
      if (!ap_rst_n) begin
         st            <= IDLE;
         kern_ap_start <= 1'b0;
         dataset_sel   <= '0;
         dataset_adv   <= 1'b0;
         busy          <= 1'b0;
         batch_done    <= 1'b0;
         iter_cnt      <= '0;
         cnt_l         <= '0;
         gap_l         <= '0;
         gcnt          <= '0;
         stop_p        <= 1'b0;
      end else begin
         dataset_adv <= 1'b0;
         batch_done  <= 1'b0;
         stop_p      <= (st != IDLE && st != FINISH) && stop;
         if (done_ev) begin
            iter_cnt    <= &iter_cnt ? iter_cnt : iter_cnt + CNT_W'(1);
            dataset_adv <= 1'b1;
            dataset_sel <= (dataset_sel == DS_W'(DATASET_NUM - 1)) ? '0 : dataset_sel + DS_W'(1);
            gcnt        <= gap_l - GAP_W'(1);
         end
         case (st)
            IDLE: if (trig_rise) begin
               iter_cnt <= '0;
               cnt_l    <= run_count_cfg;
               gap_l    <= gap_cfg;
               busy     <= 1'b1;
               st       <= ARM;
            end
            ARM: if (stop) st <= FINISH;
               else if (kern_ap_idle) begin
                  kern_ap_start <= 1'b1;
                  st            <= START;
               end
            START: if (kern_ap_ready) begin
               kern_ap_start <= 1'b0;
               st            <= kern_ap_done ? nxt : WAIT_DONE;
            end
            WAIT_DONE: if (kern_ap_done) st <= nxt;
            GAP: if (stop) st <= FINISH;
               else if (gcnt == '0) st <= ARM;
               else gcnt <= gcnt - GAP_W'(1);
            FINISH: begin
               busy       <= 1'b0;
               batch_done <= 1'b1;
               st         <= IDLE;
            end
            default: st <= IDLE;
         endcase
      end
   end

`ifdef KRUN_CYCLE_STATS_EN
   logic [CYC_W-1:0] run_cyc;
   always_ff @(posedge ap_clk or negedge ap_rst_n) begin
      if (!ap_rst_n) begin
         run_cyc      <= '0;
         last_run_cyc <= '0;
         batch_cyc    <= '0;
      end else begin
         run_cyc   <= (st == START || st == WAIT_DONE) ? run_cyc + CYC_W'(1) : '0;
         batch_cyc <= (st == IDLE && trig_rise) ? '0 :
                      (busy && !(&batch_cyc)) ? batch_cyc + CYC_W'(1) : batch_cyc;
         if (done_ev) last_run_cyc <= run_cyc + CYC_W'(1);
      end
   end
`endif
endmodule

// File: doc/kernel_run_ctrl.md
Name: kernel_run_ctrl

Overview:
Sequences repeated executions of an HLS kernel using the ap_ctrl_hs handshake (ap_start/ap_ready/ap_done/ap_idle) for power-measurement runs. A single trigger from the debug VIO starts a batch of back-to-back kernel runs with a programmable inter-run gap. The block also steps the dataset index used by the kernel_ram banks. It sits between the VIO probe and the kernel top, replacing the bare start-level pipeline.

Parameters:
CNT_W, 16, width of run-count config and iteration counter
DATASET_NUM, 8, number of datasets cycled by dataset_sel
DS_W, 3, width of dataset_sel (clog2 of DATASET_NUM, min 1)
GAP_W, 8, width of inter-run gap config
CYC_W, 32, width of cycle statistics counters (optional feature only)

Ports:
ap_clk  in  1  kernel clock
ap_rst_n  in  1  asynchronous active-low reset
trig_in  in  1  asynchronous run trigger (VIO probe); level, rising edge starts a batch
stop_req  in  1  synchronous request: finish the current run, then stop the batch
run_count_cfg  in  CNT_W  runs per batch; 0 = run until stop_req
gap_cfg  in  GAP_W  idle cycles between ap_done and the next ap_start
kern_ap_start  out  1  to kernel ap_start
kern_ap_ready  in  1  from kernel
kern_ap_done  in  1  from kernel
kern_ap_idle  in  1  from kernel
dataset_sel  out  DS_W  current dataset index
dataset_adv  out  1  one-cycle pulse on each ap_done; memories advance their dataset
busy  out  1  high from batch accept until FINISH
batch_done  out  1  one-cycle pulse when batch ends
iter_cnt  out  CNT_W  completed runs in the current or last batch

Behaviour:
- Reset values: all outputs 0, state IDLE, synchronizer flops 0.
- trig_in passes through a 2-flop synchronizer followed by a rising-edge detect. trig_rise appears 3 cycles after the input edge. Edges arriving while busy are ignored, not queued.
- States:
  - IDLE: on trig_rise, clear iter_cnt and latch run_count_cfg and gap_cfg. busy<=1, go to ARM.
  - ARM: wait for kern_ap_idle=1, then go to START.
  - START: kern_ap_start=1 (registered). Held until kern_ap_ready is sampled high, then deasserted next cycle and go to WAIT_DONE.
  - WAIT_DONE: wait for kern_ap_done.
  - GAP: count down the latched gap, then go to ARM. gap 0 means ARM is entered the cycle after done.
  - FINISH: busy<=0, pulse batch_done, go to IDLE.
- On each kern_ap_done (any state after START):
  - iter_cnt increments.
  - dataset_adv pulses.
  - dataset_sel increments, wrapping DATASET_NUM-1 -> 0.
  - Next state is FINISH if (latched count != 0 and iter_cnt+1 == latched count) or a stop is pending. Otherwise it is GAP.
- ready and done in the same cycle while in START: treated as ready followed by done. kern_ap_start drops, done processing is as above, and WAIT_DONE is skipped.
- stop_req is sticky until FINISH and never truncates a started run. stop_req in ARM or GAP goes directly to FINISH without a further start.
- iter_cnt saturates at all-ones when run_count_cfg=0.
- dataset_sel is not reset between batches; it resets only on ap_rst_n.
- Asserting reset mid-run forces IDLE and drops kern_ap_start immediately (asynchronous). The kernel must be reset by the same reset.

Optional Feature:
KRUN_CYCLE_STATS_EN
- Defined: adds outputs last_run_cyc and batch_cyc (CYC_W each).
  - last_run_cyc counts cycles from the first kern_ap_start=1 cycle to the kern_ap_done cycle inclusive. It is latched on done.
  - batch_cyc counts all busy cycles, saturating at all-ones.
  - Both reset to 0; batch_cyc also clears on batch accept.
- Undefined: neither port nor counter exists. Timing and behaviour are otherwise identical.

Decomposition:
- Shared package krun_pkg holds:
  - the state enum (IDLE, ARM, START, WAIT_DONE, GAP, FINISH);
  - the default widths;
  - the DATASET_NUM constant shared with kernel_ram.
- One sub-module, sync_edge_det: 2-flop synchronizer plus rising-edge pulse, reset by ap_rst_n. It is reused for other VIO inputs.

Test Plan:
- Reset, then trig_in rises with run_count_cfg=3, gap_cfg=4 and a kernel model (ready 1 cycle after start, done 20 cycles later):
  - exactly 3 start/done pairs;
  - 4 idle cycles between each done and the next start;
  - iter_cnt=3, dataset_sel=3, three dataset_adv pulses, one batch_done.
- Kernel model asserting ready and done together in the start cycle, run_count_cfg=2, gap_cfg=0 -> 2 runs, no hang, kern_ap_start high for exactly 1 cycle per run.
- run_count_cfg=0, stop_req pulsed during the 5th WAIT_DONE -> 5th run completes, batch_done follows, iter_cnt=5, no 6th start.
- 10 runs with DATASET_NUM=8 -> dataset_sel sequence 1..7,0,1,2; second trig_rise while busy is ignored.
- ap_rst_n asserted mid-START -> kern_ap_start low in the same cycle, busy=0, dataset_sel=0, iter_cnt=0; a later trig restarts cleanly.
- With KRUN_CYCLE_STATS_EN, ready at +1 and done at +20 -> last_run_cyc=21 after each run.
